// File: rtl/glitch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_pkg
//  Purpose  : Shared types and helpers for the glitch sweep sequencer:
//             FSM state encoding, delay-mode constants, channel width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package glitch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_OBSERVE = 3'd4,
    ST_HALTED  = 3'd5
  } state_e;

  // Delay counting mode, latched when a run starts
  localparam logic MODE_CLK = 1'b0;
  localparam logic MODE_EXI = 1'b1;

  // Channel index width; a single channel still needs a 1-bit index
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/glitch_sweep_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_sweep_seq_if
//  Purpose  : Control/status bundle between the glitch sweep sequencer and
//             its controller. The slave modport is the sequencer view.
//  Revision : 1.0 - initial release
// ============================================================================
interface glitch_sweep_seq_if
  import glitch_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int NUM_CH = 2,
  parameter int CH_W   = ch_width(NUM_CH)
);

  // Controller -> sequencer
  logic              start_i;
  logic              abort_i;
  logic              clear_i;
  logic              mode_i;
  logic              exi_clk_i;
  logic              success_i;

  // Sequencer -> target / controller
  logic              target_reset_n_o;
  logic [NUM_CH-1:0] glitch_out_o;
  logic              busy_o;
  logic              halted_o;
  logic              attempt_done_o;
  logic              sweep_wrap_o;
  logic              timeout_o;
  logic [CNT_W-1:0]  cur_delay_o;
  logic [CNT_W-1:0]  cur_len_o;
  logic [CH_W-1:0]   cur_ch_o;

  modport slave (
    input  start_i, abort_i, clear_i, mode_i, exi_clk_i, success_i,
    output target_reset_n_o, glitch_out_o, busy_o, halted_o,
           attempt_done_o, sweep_wrap_o, timeout_o,
           cur_delay_o, cur_len_o, cur_ch_o
  );

  modport master (
    output start_i, abort_i, clear_i, mode_i, exi_clk_i, success_i,
    input  target_reset_n_o, glitch_out_o, busy_o, halted_o,
           attempt_done_o, sweep_wrap_o, timeout_o,
           cur_delay_o, cur_len_o, cur_ch_o
  );

endinterface
`default_nettype wire

// File: rtl/sweep_odometer.sv
`default_nettype none
// ============================================================================
//  Module   : sweep_odometer
//  Purpose  : Nested delay -> length -> channel counters. Delay is the
//             fastest digit; each digit wraps to its minimum and carries into
//             the next. wrap_o flags the carry out of the channel digit.
//  Revision : 1.0 - initial release
// ============================================================================
module sweep_odometer
  import glitch_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int NUM_CH    = 2,
  parameter int DELAY_MIN = 1,
  parameter int DELAY_MAX = 768,
  parameter int LEN_MIN   = 256,
  parameter int LEN_MAX   = 384,
  parameter int CH_W      = ch_width(NUM_CH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear_i,
  input  wire logic             advance_i,
  output logic      [CNT_W-1:0] delay_o,
  output logic      [CNT_W-1:0] len_o,
  output logic      [CH_W-1:0]  ch_o,
  output logic                  wrap_o
);

  localparam logic [CNT_W-1:0] D_MIN  = CNT_W'(DELAY_MIN);
  localparam logic [CNT_W-1:0] D_MAX  = CNT_W'(DELAY_MAX);
  localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(LEN_MIN);
  localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(LEN_MAX);
  localparam logic [CH_W-1:0]  CH_MAX = CH_W'(NUM_CH - 1);

  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] len_q,   len_d;
  logic [CH_W-1:0]  ch_q,    ch_d;

  // Next index: clear beats advance; carries ripple delay -> len -> ch
  always_comb begin
    delay_d = delay_q;
    len_d   = len_q;
    ch_d    = ch_q;
    wrap_o  = 1'b0;
    if (clear_i) begin
      delay_d = D_MIN;
      len_d   = L_MIN;
      ch_d    = '0;
    end else if (advance_i) begin
      if (delay_q != D_MAX) begin
        delay_d = delay_q + 1'b1;
      end else begin
        delay_d = D_MIN;
        if (len_q != L_MAX) begin
          len_d = len_q + 1'b1;
        end else begin
          len_d = L_MIN;
          if (ch_q != CH_MAX) begin
            ch_d = ch_q + 1'b1;
          end else begin
            ch_d   = '0;
            wrap_o = 1'b1;
          end
        end
      end
    end
  end

  // Index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_q <= D_MIN;
      len_q   <= L_MIN;
      ch_q    <= '0;
    end else begin
      delay_q <= delay_d;
      len_q   <= len_d;
      ch_q    <= ch_d;
    end
  end

  assign delay_o = delay_q;
  assign len_o   = len_q;
  assign ch_o    = ch_q;

endmodule
`default_nettype wire

// File: rtl/glitch_sweep_seq.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_sweep_seq
//  Purpose  : Fault-injection sequencer. Each attempt holds the target in
//             reset, waits a delay (CLK cycles or EXI rising edges), fires one
//             glitch pulse on the selected channel, then watches for success.
//             Failed attempts advance the delay/length/channel sweep; success
//             freezes the sweep with the target running.
//  Revision : 1.0 - initial release
// ============================================================================
module glitch_sweep_seq
  import glitch_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int NUM_CH         = 2,
  parameter int RESET_CYCLES   = 512,
  parameter int DELAY_MIN      = 1,
  parameter int DELAY_MAX      = 768,
  parameter int LEN_MIN        = 256,
  parameter int LEN_MAX        = 384,
  parameter int OBS_W          = 24,
  parameter int OBSERVE_CYCLES = 983040
) (
  input wire logic           clk,
  input wire logic           rst,
  glitch_sweep_seq_if.slave  bus
);

  localparam int               CH_W     = ch_width(NUM_CH);
  localparam logic [OBS_W-1:0] RST_LAST = OBS_W'(RESET_CYCLES - 1);
  localparam logic [OBS_W-1:0] OBS_LAST = OBS_W'(OBSERVE_CYCLES - 1);

  if (LEN_MIN < 1) begin : g_len_min_check
    $error("glitch_sweep_seq: LEN_MIN must be at least 1");
  end

  state_e            state_q, state_d;
  logic [OBS_W-1:0]  timer_q, timer_d;     // reset hold, EXI timeout, observe
  logic [CNT_W-1:0]  cnt_q,   cnt_d;       // delay cycles/edges, pulse length
  logic              mode_q,  mode_d;

  logic [2:0]        exi_sync_q;
  logic              exi_rise_q;

  logic              sweep_clear;
  logic              sweep_adv;
  logic              sweep_wrap;
  logic              done_d;
  logic              tmo_d;
  logic [NUM_CH-1:0] ch_onehot;

  logic [CNT_W-1:0]  cur_delay;
  logic [CNT_W-1:0]  cur_len;
  logic [CH_W-1:0]   cur_ch;

  logic              tr_n_q;
  logic [NUM_CH-1:0] glitch_q;
  logic              busy_q;
  logic              halted_q;
  logic              done_q;
  logic              wrap_q;
  logic              tmo_q;

  sweep_odometer #(
    .CNT_W     (CNT_W),
    .NUM_CH    (NUM_CH),
    .DELAY_MIN (DELAY_MIN),
    .DELAY_MAX (DELAY_MAX),
    .LEN_MIN   (LEN_MIN),
    .LEN_MAX   (LEN_MAX),
    .CH_W      (CH_W)
  ) u_odometer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (sweep_clear),
    .advance_i (sweep_adv),
    .delay_o   (cur_delay),
    .len_o     (cur_len),
    .ch_o      (cur_ch),
    .wrap_o    (sweep_wrap)
  );

  // Two-flop synchroniser on the raw EXI clock plus a registered rising-edge
  // strobe, giving three CLK cycles from pad to strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exi_sync_q <= '0;
      exi_rise_q <= 1'b0;
    end else begin
      exi_sync_q <= {exi_sync_q[1:0], bus.exi_clk_i};
      exi_rise_q <= exi_sync_q[1] & ~exi_sync_q[2];
    end
  end

  // Next state, counters and sweep control; abort overrides everything
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    sweep_clear = 1'b0;
    sweep_adv   = 1'b0;
    done_d      = 1'b0;
    tmo_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sweep_clear = bus.clear_i;
        if (bus.start_i) begin
          state_d = ST_RESET;
          mode_d  = bus.mode_i;
          timer_d = '0;
        end
      end
      ST_RESET: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == RST_LAST) begin
          timer_d = '0;
          cnt_d   = '0;
          // A zero delay glitches on the very first released cycle
          state_d = (cur_delay == '0) ? ST_PULSE : ST_DELAY;
        end
      end
      ST_DELAY: begin
        timer_d = timer_q + 1'b1;
        if (mode_q == MODE_EXI) begin
          if (exi_rise_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == cur_delay - CNT_W'(1)) begin
              state_d = ST_PULSE;
              cnt_d   = '0;
            end
          end else if (timer_q == OBS_LAST) begin
            // Target never clocked: skip the glitch, still observe
            tmo_d   = 1'b1;
            state_d = ST_OBSERVE;
            timer_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == cur_delay - CNT_W'(1)) begin
            state_d = ST_PULSE;
            cnt_d   = '0;
          end
        end
      end
      ST_PULSE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == cur_len - CNT_W'(1)) begin
          state_d = ST_OBSERVE;
          timer_d = '0;
        end
      end
      ST_OBSERVE: begin
        timer_d = timer_q + 1'b1;
        if (bus.success_i) begin
          state_d = ST_HALTED;
        end else if (timer_q == OBS_LAST) begin
          done_d    = 1'b1;
          sweep_adv = 1'b1;
          state_d   = ST_RESET;
          timer_d   = '0;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (bus.abort_i) begin
      state_d   = ST_IDLE;
      sweep_adv = 1'b0;
      done_d    = 1'b0;
      tmo_d     = 1'b0;
    end
  end

  // One-hot channel select from the current channel index
  always_comb begin
    ch_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_onehot[i] = (cur_ch == CH_W'(i));
    end
  end

  // FSM and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_CLK;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Outputs registered from the next state so the target pins stay glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tr_n_q   <= 1'b1;
      glitch_q <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      tr_n_q   <= (state_d != ST_RESET);
      glitch_q <= (state_d == ST_PULSE) ? ch_onehot : '0;
      busy_q   <= (state_d != ST_IDLE) && (state_d != ST_HALTED);
      halted_q <= (state_d == ST_HALTED);
      done_q   <= done_d;
      wrap_q   <= sweep_wrap;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.target_reset_n_o = tr_n_q;
  assign bus.glitch_out_o     = glitch_q;
  assign bus.busy_o           = busy_q;
  assign bus.halted_o         = halted_q;
  assign bus.attempt_done_o   = done_q;
  assign bus.sweep_wrap_o     = wrap_q;
  assign bus.timeout_o        = tmo_q;
  assign bus.cur_delay_o      = cur_delay;
  assign bus.cur_len_o        = cur_len;
  assign bus.cur_ch_o         = cur_ch;

endmodule
`default_nettype wire

// File: tb/tb_glitch_sweep_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glitch_sweep_seq
//  Purpose  : Self-checking bench for glitch_sweep_seq with a small sweep
//             (reset 4, delay 1..3, length 2..3, 2 channels, observe 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_glitch_sweep_seq;
  import glitch_pkg::*;

  localparam int CNT_W  = 16;
  localparam int NUM_CH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  glitch_sweep_seq_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) bus ();

  glitch_sweep_seq #(
    .CNT_W          (CNT_W),
    .NUM_CH         (NUM_CH),
    .RESET_CYCLES   (4),
    .DELAY_MIN      (1),
    .DELAY_MAX      (3),
    .LEN_MIN        (2),
    .LEN_MAX        (3),
    .OBS_W          (24),
    .OBSERVE_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int d;
    int l;
    int ch;
    int wrap;
  } att_t;

  att_t tbl[12];
  att_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Follows one attempt from reset assertion to attempt_done (or halt)
  task automatic run_attempt(input bit hold_succ,
                             output int rlo, output int dly, output int len, output int obs,
                             output logic [NUM_CH-1:0] g, output logic [CNT_W-1:0] d,
                             output logic [CNT_W-1:0] l, output logic ch,
                             output logic wrap, output logic done);
    int guard;
    rlo = 0; dly = 0; len = 0; obs = 0; g = '0; d = '0; l = '0; ch = 1'b0;
    wrap = 1'b0; done = 1'b0; guard = 0;
    if (hold_succ) bus.success_i = 1'b1;
    while (bus.target_reset_n_o !== 1'b0 && guard < 300) begin @(negedge clk); guard++; end
    while (bus.target_reset_n_o === 1'b0 && guard < 300) begin rlo++; @(negedge clk); guard++; end
    while (bus.glitch_out_o === '0 && guard < 300) begin dly++; @(negedge clk); guard++; end
    g = bus.glitch_out_o; d = bus.cur_delay_o; l = bus.cur_len_o; ch = bus.cur_ch_o;
    while (bus.glitch_out_o !== '0 && guard < 300) begin len++; @(negedge clk); guard++; end
    while (bus.attempt_done_o !== 1'b1 && bus.halted_o !== 1'b1 && guard < 300) begin
      obs++; @(negedge clk); guard++;
    end
    wrap = bus.sweep_wrap_o;
    done = bus.attempt_done_o;
    bus.success_i = 1'b0;
    chk("attempt_bound", (guard < 300), 1);
  endtask

  task automatic pulse_start(input logic m, input logic clr);
    bus.start_i = 1'b1; bus.mode_i = m; bus.clear_i = clr;
    @(negedge clk);
    bus.start_i = 1'b0; bus.clear_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    att_t              e;
    int                rlo, dly, len, obs, tfirst, tcnt, dfirst, guard;
    logic [NUM_CH-1:0] g;
    logic [CNT_W-1:0]  d, l;
    logic              ch, wrap, done, bad, gseen;

    tbl[0]  = '{1, 2, 0, 0}; tbl[1]  = '{2, 2, 0, 0}; tbl[2]  = '{3, 2, 0, 0};
    tbl[3]  = '{1, 3, 0, 0}; tbl[4]  = '{2, 3, 0, 0}; tbl[5]  = '{3, 3, 0, 0};
    tbl[6]  = '{1, 2, 1, 0}; tbl[7]  = '{2, 2, 1, 0}; tbl[8]  = '{3, 2, 1, 0};
    tbl[9]  = '{1, 3, 1, 0}; tbl[10] = '{2, 3, 1, 0}; tbl[11] = '{3, 3, 1, 1};

    rst = 1'b1;
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.clear_i = 1'b0;
    bus.mode_i = 1'b0; bus.exi_clk_i = 1'b0; bus.success_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_target_reset_n", bus.target_reset_n_o, 1);
    chk("rst_glitch_out", bus.glitch_out_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_halted", bus.halted_o, 0);
    chk("rst_attempt_done", bus.attempt_done_o, 0);
    chk("rst_sweep_wrap", bus.sweep_wrap_o, 0);
    chk("rst_timeout", bus.timeout_o, 0);
    chk("rst_cur_delay", bus.cur_delay_o, 1);
    chk("rst_cur_len", bus.cur_len_o, 2);
    chk("rst_cur_ch", bus.cur_ch_o, 0);

    // Full sweep plus most of a second pass; expectations queued at start
    for (int k = 0; k < 23; k++) sb_q.push_back(tbl[k % 12]);
    pulse_start(MODE_CLK, 1'b1);
    chk("busy_after_start", bus.busy_o, 1);
    for (int k = 0; k < 22; k++) begin
      run_attempt(1'b0, rlo, dly, len, obs, g, d, l, ch, wrap, done);
      chk("sb_not_empty", (sb_q.size() > 0), 1);
      e = sb_q.pop_front();
      chk("reset_low_cycles", rlo, 4);
      chk("delay_cycles", dly, e.d);
      chk("pulse_len", len, e.l);
      chk("glitch_channel", g, 1 << e.ch);
      chk("cur_delay", d, e.d);
      chk("cur_len", l, e.l);
      chk("cur_ch", ch, e.ch);
      chk("observe_cycles", obs, 8);
      chk("attempt_done", done, 1);
      chk("sweep_wrap", wrap, e.wrap);
    end

    // Attempt (2,3,1) with success held throughout: only OBSERVE may react
    run_attempt(1'b1, rlo, dly, len, obs, g, d, l, ch, wrap, done);
    e = sb_q.pop_front();
    chk("succ_delay_cycles", dly, e.d);
    chk("succ_pulse_len", len, e.l);
    chk("succ_glitch_channel", g, 1 << e.ch);
    chk("succ_observe_cycles", obs, 1);
    chk("succ_halted", bus.halted_o, 1);
    chk("succ_no_attempt_done", done, 0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.target_reset_n_o !== 1'b1 || bus.glitch_out_o !== '0 || bus.halted_o !== 1'b1)
        bad = 1'b1;
    end
    chk("halt_hold", bad, 0);
    chk("halt_busy", bus.busy_o, 0);
    chk("halt_cur_delay", bus.cur_delay_o, 2);
    chk("halt_cur_len", bus.cur_len_o, 3);
    chk("halt_cur_ch", bus.cur_ch_o, 1);
    pulse_start(MODE_CLK, 1'b0);
    @(negedge clk);
    chk("halt_ignores_start", bus.halted_o, 1);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("abort_halt_halted", bus.halted_o, 0);
    chk("abort_halt_busy", bus.busy_o, 0);
    chk("abort_halt_tr_n", bus.target_reset_n_o, 1);
    chk("abort_halt_keep_delay", bus.cur_delay_o, 2);
    chk("abort_halt_keep_ch", bus.cur_ch_o, 1);

    // Asynchronous reset in the middle of a pulse
    pulse_start(MODE_CLK, 1'b0);
    guard = 0;
    while (bus.glitch_out_o === '0 && guard < 100) begin @(negedge clk); guard++; end
    chk("rst_mid_pulse_reached", (guard < 100), 1);
    chk("rst_mid_pulse_channel", bus.glitch_out_o, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_glitch", bus.glitch_out_o, 0);
    chk("async_rst_tr_n", bus.target_reset_n_o, 1);
    chk("async_rst_busy", bus.busy_o, 0);
    chk("async_rst_delay", bus.cur_delay_o, 1);
    chk("async_rst_len", bus.cur_len_o, 2);
    chk("async_rst_ch", bus.cur_ch_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // One attempt, then abort while the next reset phase is running
    pulse_start(MODE_CLK, 1'b0);
    run_attempt(1'b0, rlo, dly, len, obs, g, d, l, ch, wrap, done);
    chk("pre_abort_done", done, 1);
    chk("pre_abort_in_reset", bus.target_reset_n_o, 0);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("abort_reset_tr_n", bus.target_reset_n_o, 1);
    chk("abort_reset_busy", bus.busy_o, 0);
    chk("abort_reset_keep_delay", bus.cur_delay_o, 2);

    // EXI mode, delay 2: pad edges 5 CLK apart, first lands during reset
    bus.start_i = 1'b1; bus.mode_i = MODE_EXI;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 1) bus.start_i = 1'b0;
      if (i == 4) chk("exi_reset_still_low", bus.target_reset_n_o, 0);
      if (i == 5) chk("exi_released", bus.target_reset_n_o, 1);
      if (i == 10) chk("exi_no_pulse_yet", bus.glitch_out_o, 0);
      if (i == 11) chk("exi_pulse_start", bus.glitch_out_o, 2'b01);
      if (i == 2 || i == 7) bus.exi_clk_i = 1'b1;
      if (i == 4 || i == 9) bus.exi_clk_i = 1'b0;
    end
    guard = 0;
    while (bus.attempt_done_o !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    chk("exi_attempt_done", bus.attempt_done_o, 1);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("exi_advanced_delay", bus.cur_delay_o, 3);

    // EXI mode without edges: timeout, no glitch, attempt_done after observe
    tfirst = -1; tcnt = 0; dfirst = -1; gseen = 1'b0;
    bus.start_i = 1'b1; bus.mode_i = MODE_EXI;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (i == 1) bus.start_i = 1'b0;
      if (bus.glitch_out_o !== '0) gseen = 1'b1;
      if (bus.timeout_o === 1'b1) begin
        if (tfirst < 0) tfirst = i;
        tcnt++;
      end
      if (bus.attempt_done_o === 1'b1 && dfirst < 0) dfirst = i;
    end
    chk("timeout_cycle", tfirst, 13);
    chk("timeout_width", tcnt, 1);
    chk("timeout_no_glitch", gseen, 0);
    chk("timeout_done_cycle", dfirst, 21);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("timeout_adv_delay", bus.cur_delay_o, 1);
    chk("timeout_adv_len", bus.cur_len_o, 3);
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
    chk("clear_delay", bus.cur_delay_o, 1);
    chk("clear_len", bus.cur_len_o, 2);
    chk("clear_ch", bus.cur_ch_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/glitch_sweep_seq.md
Name: glitch_sweep_seq

Overview:
Parametrised multi-channel glitch sequencer for target fault-injection runs. It repeatedly resets the target and waits a programmable delay, counted either in CLK cycles or in target EXI clock edges. It then fires one glitch pulse on a selected channel and observes the target for a success flag. Delay, pulse length and channel are swept as a nested odometer. The sweep freezes on success, keeping the target out of reset with the winning parameters exposed.

Parameters:
CNT_W, 16, width of delay/length counters and status outputs
NUM_CH, 2, number of glitch output channels
RESET_CYCLES, 512, target reset hold length in CLK cycles
DELAY_MIN, 1, first delay value
DELAY_MAX, 768, last delay value (inclusive)
LEN_MIN, 256, first pulse length (must be >=1, elaboration error otherwise)
LEN_MAX, 384, last pulse length (inclusive)
OBS_W, 24, width of observe/timeout timer
OBSERVE_CYCLES, 983040, post-glitch observe window; also EXI-mode delay timeout

Ports:
CLK  in  1  system clock
RST  in  1  async active-high reset
start  in  1  level-sampled; begins run from IDLE
abort  in  1  return to IDLE from any state
clear  in  1  reset sweep indices to minimums; honoured only in IDLE
mode  in  1  0 = delay in CLK cycles, 1 = delay in EXI rising edges; sampled at start
exi_clk  in  1  raw target EXI clock, asynchronous
success  in  1  synchronous success flag from debug-port decoder
target_reset_n  out  1  target reset, active-low
glitch_out  out  NUM_CH  glitch triggers, active-high, at most one bit set
busy  out  1  high outside IDLE and HALTED
halted  out  1  high in HALTED
attempt_done  out  1  one-cycle pulse at end of each failed attempt
sweep_wrap  out  1  one-cycle pulse when the full sweep wraps
timeout  out  1  one-cycle pulse on EXI-mode delay timeout
cur_delay  out  CNT_W  current delay index
cur_len  out  CNT_W  current pulse length
cur_ch  out  $clog2(NUM_CH) (min 1)  current channel

Behaviour:
- Reset: state IDLE; target_reset_n=1; glitch_out=0; all pulses 0; busy=halted=0; cur_delay=DELAY_MIN; cur_len=LEN_MIN; cur_ch=0.
- exi_clk passes through a 2-FF synchroniser. Edge detect uses the synchronised signal, so latency is 3 CLK from the pad.
- States: IDLE, RESET, DELAY, PULSE, OBSERVE, HALTED.
- IDLE: start=1 -> RESET next cycle and latch mode. start while busy is ignored.
- RESET: target_reset_n=0 for exactly RESET_CYCLES cycles, then DELAY.
- DELAY, mode 0: the first cycle with target_reset_n=1 is count 0. PULSE begins after cur_delay cycles, so delay 0 means PULSE starts on the first released cycle.
- DELAY, mode 1: count cur_delay synchronised rising edges; PULSE begins the cycle after the qualifying edge.
- DELAY, mode 1 timeout: if OBSERVE_CYCLES elapse in DELAY, pulse timeout, skip PULSE and go to OBSERVE.
- PULSE: glitch_out[cur_ch]=1 for exactly cur_len cycles, then OBSERVE with glitch_out=0.
- OBSERVE: runs for OBSERVE_CYCLES cycles.
  - success=1 in any OBSERVE cycle -> HALTED next cycle; indices frozen.
  - On expiry: pulse attempt_done, advance sweep, go to RESET.
- Sweep advance: cur_delay++. When cur_delay==DELAY_MAX it wraps to DELAY_MIN and cur_len++.
  - When cur_len==LEN_MAX it wraps to LEN_MIN and cur_ch++.
  - When cur_ch==NUM_CH-1 it wraps to 0 and sweep_wrap pulses in the same cycle as attempt_done.
- HALTED: target_reset_n=1, glitch_out=0. Only abort or RST leaves it (abort -> IDLE, indices kept).
- abort: from any state, IDLE next cycle; glitch_out and target_reset_n release in that cycle; indices kept; a pending advance is dropped.
- success outside OBSERVE is ignored. abort and success in the same cycle: abort wins.
- clear with start in the same IDLE cycle: clear applied first, run starts from the minimums.
- RST mid-run: asynchronous return to reset values, including target_reset_n=1 and glitch_out=0.

Decomposition:
- Package glitch_pkg: state enum, mode constants (MODE_CLK, MODE_EXI), channel-width function.
- Sub-module sweep_odometer: nested delay/len/ch counters with clear, advance, and wrap output.
- Edge synchroniser is inline.

Test Plan:
- Bench params RESET_CYCLES=4, DELAY 1..3, LEN 2..3, NUM_CH=2, OBSERVE_CYCLES=8, mode 0:
  - start -> target_reset_n low 4 cycles; glitch_out[0] rises exactly 1 cycle after release and is high 2 cycles; attempt_done 8 cycles later.
  - Run full sweep -> 12 attempt_done pulses in order (d,l,ch) = (1,2,0)(2,2,0)(3,2,0)(1,3,0)...(3,3,1); sweep_wrap on the 12th.
- Mode 1, delay 2: feed EXI edges every 5 CLK -> pulse starts 3 CLK + 1 after the second synchronised edge.
- Mode 1 with no EXI edges -> timeout after 8 cycles; no glitch_out; attempt_done follows OBSERVE.
- success asserted in OBSERVE of attempt (2,3,1) -> halted=1, target_reset_n stays 1 indefinitely, cur_* = 2,3,1; abort -> IDLE.
- RST asserted mid-PULSE -> glitch_out=0 and target_reset_n=1 asynchronously; indices back to minimums.
- abort during RESET plus clear in IDLE -> target_reset_n=1 next cycle; indices back to minimums.
